// File: rtl/regfile_read_port.sv
// Read-side controller for a tri-state register file. It turns a dual-address request into
// one-hot bus enables, samples both buses after a settle cycle, and returns the two values.
module regfile_read_port #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr_a,
    input  logic [AW-1:0]    req_addr_b,
    output logic [DEPTH-1:0] ReadA,
    output logic [DEPTH-1:0] ReadB,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data_a,
    output logic [WIDTH-1:0] rsp_data_b
);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCapture,
        StResp
    } state_e;

    state_e           stateQ, stateD;
    logic [AW-1:0]    addrAQ, addrAD;
    logic [AW-1:0]    addrBQ, addrBD;
    logic [DEPTH-1:0] readAD, readBD;
    logic             rspValidD;
    logic [WIDTH-1:0] dataAD, dataBD;

    // A hard-wired zero register never gets its cell enabled, so the bus simply floats.
    function automatic logic [DEPTH-1:0] decodeAddr(input logic [AW-1:0] addr);
        logic [DEPTH-1:0] vec;
        vec = '0;
        if (!(ZERO_REG && (addr == '0))) begin
            vec[addr] = 1'b1;
        end
        return vec;
    endfunction

    always_comb begin
        stateD    = stateQ;
        addrAD    = addrAQ;
        addrBD    = addrBQ;
        readAD    = ReadA;
        readBD    = ReadB;
        rspValidD = rsp_valid;
        dataAD    = rsp_data_a;
        dataBD    = rsp_data_b;
        req_ready = (stateQ == StIdle);

        unique case (stateQ)
            StIdle: begin
                if (req_valid) begin
                    addrAD = req_addr_a;
                    addrBD = req_addr_b;
                    readAD = decodeAddr(req_addr_a);
                    readBD = decodeAddr(req_addr_b);
                    stateD = StDrive;
                end
            end
            StDrive: begin
                stateD = StCapture;
            end
            StCapture: begin
                // Sampled on the same edge a cell write lands, so the old value is returned.
                dataAD    = (ZERO_REG && (addrAQ == '0)) ? '0 : BusA;
                dataBD    = (ZERO_REG && (addrBQ == '0)) ? '0 : BusB;
                readAD    = '0;
                readBD    = '0;
                rspValidD = 1'b1;
                stateD    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rspValidD = 1'b0;
                    stateD    = StIdle;
                end
            end
            default: begin
                readAD    = '0;
                readBD    = '0;
                rspValidD = 1'b0;
                stateD    = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateQ     <= StIdle;
            addrAQ     <= '0;
            addrBQ     <= '0;
            ReadA      <= '0;
            ReadB      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data_a <= '0;
            rsp_data_b <= '0;
        end else begin
            stateQ     <= stateD;
            addrAQ     <= addrAD;
            addrBQ     <= addrBD;
            ReadA      <= readAD;
            ReadB      <= readBD;
            rsp_valid  <= rspValidD;
            rsp_data_a <= dataAD;
            rsp_data_b <= dataBD;
        end
    end

endmodule
